// File: rtl/bram_writer_pkg.sv
// Shared types and constants for the ping-pong frame BRAM writer.
`timescale 1ns/1ps
package bram_writer_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic {
    ST_WAIT_BANK = 1'b0,
    ST_WRITING   = 1'b1
  } state_t;

endpackage

// File: rtl/bram_writer_in.sv
// Writes a pixel stream into two alternating frame banks, stalling while the next bank is still full.
// Optional BRAM_WRITER_SOF_EN adds in_sof framing and a sync_error pulse.
`timescale 1ns/1ps
module bram_writer_in
  import bram_writer_pkg::*;
#(
  parameter int width      = 120,
  parameter int height     = 240,
  parameter int frame_size = width * height,
  parameter int addr_bits  = $clog2(frame_size),
  parameter int data_width = 21
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [addr_bits-1:0]  wr_address,
  output logic [data_width-1:0] wr_data,
  output logic                  wr_bram_index,
  output logic                  frame_done,
  output logic                  done_bram_index,
  input  logic                  bank_release,
  input  logic                  release_index,
`ifdef BRAM_WRITER_SOF_EN
  input  logic                  in_sof,
  output logic                  sync_error,
`endif
  output logic [NUM_BANKS-1:0]  bank_full
);

  localparam logic [addr_bits-1:0] LAST_ADDR = addr_bits'(frame_size - 1);

  state_t                 state;
  state_t                 state_next;
  logic [addr_bits-1:0]   counter;
  logic                   cur_bank;
  logic                   accept;
  logic                   do_write;
  logic                   last_beat;
  logic [addr_bits-1:0]   beat_addr;
  logic [NUM_BANKS-1:0]   full_next;

`ifdef BRAM_WRITER_SOF_EN
  logic                   synced;
`endif

  always_comb begin
    accept = in_valid && in_ready;
`ifdef BRAM_WRITER_SOF_EN
    // A start-of-frame beat always lands at address 0, realigning a drifted frame.
    beat_addr = in_sof ? '0 : counter;
    do_write  = accept && (synced || in_sof);
`else
    beat_addr = counter;
    do_write  = accept;
`endif
    last_beat = do_write && (beat_addr == LAST_ADDR);

    // Release is applied before the fill so a coincident release of the other bank avoids a stall.
    full_next = bank_full;
    if (bank_release)
      full_next[release_index] = 1'b0;
    if (last_beat)
      full_next[cur_bank] = 1'b1;

    state_next = state;
    case (state)
      ST_WRITING:   if (last_beat) state_next = full_next[!cur_bank] ? ST_WAIT_BANK : ST_WRITING;
      ST_WAIT_BANK: if (!full_next[cur_bank]) state_next = ST_WRITING;
      default:      state_next = ST_WRITING;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_WRITING;
      in_ready        <= 1'b0;
      wr_en           <= 1'b0;
      wr_address      <= '0;
      wr_data         <= '0;
      wr_bram_index   <= 1'b0;
      frame_done      <= 1'b0;
      done_bram_index <= 1'b0;
      bank_full       <= '0;
      counter         <= '0;
      cur_bank        <= 1'b0;
`ifdef BRAM_WRITER_SOF_EN
      synced          <= 1'b0;
      sync_error      <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      in_ready   <= (state_next == ST_WRITING);
      bank_full  <= full_next;
      wr_en      <= do_write;
      frame_done <= last_beat;
      if (do_write) begin
        wr_address    <= beat_addr;
        wr_data       <= in_data;
        wr_bram_index <= cur_bank;
        counter       <= last_beat ? '0 : beat_addr + 1'b1;
      end
      if (last_beat) begin
        cur_bank        <= !cur_bank;
        done_bram_index <= cur_bank;
      end
`ifdef BRAM_WRITER_SOF_EN
      if (accept && in_sof)
        synced <= 1'b1;
      sync_error <= do_write && in_sof && (counter != '0);
`endif
    end
  end

endmodule
